// File: rtl/accumulate_pkg.sv
// accumulate_pkg: shared constants, sequencer states and array word types for the accumulate host bridge.
package accumulate_pkg;
    localparam int DEPTH = 1000;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/accumulate_host_bridge_if.sv
// accumulate_host_bridge_if: host-side command, load-stream and drain-stream handshakes.
interface accumulate_host_bridge_if;
    import accumulate_pkg::*;
    logic  cmd_valid;
    logic  cmd_ready;
    addr_t cmd_init_i;
    data_t cmd_init_acc;
    logic  in_valid;
    logic  in_ready;
    data_t in_data;
    logic  out_valid;
    logic  out_ready;
    data_t out_data;
    logic  out_last;
    logic  busy;
    modport master (
        output cmd_valid, cmd_init_i, cmd_init_acc, in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data, out_last, busy
    );
    modport slave (
        input  cmd_valid, cmd_init_i, cmd_init_acc, in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/accumulate_host_bridge_skid_buffer.sv
// bridge_skid_buffer: output register plus one skid entry; pushes arrive one cycle after the read issues.
module bridge_skid_buffer
    import accumulate_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  data_t      i_data,
    input  logic       i_last,
    input  logic       i_ready,
    output logic       o_valid,
    output data_t      o_data,
    output logic       o_last,
    output logic [1:0] o_count
);
    logic  r_v0, r_v1, r_l0, r_l1;
    data_t r_d0, r_d1;
    logic  w_take;
    assign w_take  = !r_v0 || i_ready;
    assign o_valid = r_v0;
    assign o_data  = r_d0;
    assign o_last  = r_l0;
    assign o_count = 2'(r_v0) + 2'(r_v1);
    // The output register only refreshes when empty or popped, so it holds steady under stall.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_l0 <= 1'b0;
            r_l1 <= 1'b0;
            r_d0 <= '0;
            r_d1 <= '0;
        end else if (w_take) begin
            r_v0 <= r_v1 || i_push;
            r_d0 <= r_v1 ? r_d1 : i_data;
            r_l0 <= r_v1 ? r_l1 : i_last;
            r_v1 <= r_v1 && i_push;
            r_d1 <= i_data;
            r_l1 <= i_last;
        end else if (i_push) begin
            r_v1 <= 1'b1;
            r_d1 <= i_data;
            r_l1 <= i_last;
        end
endmodule

// File: rtl/accumulate_host_bridge.sv
// accumulate_host_bridge: loads the accumulate core's array, runs the core, then drains the array back out.
module accumulate_host_bridge
    import accumulate_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    accumulate_host_bridge_if.slave host,
    output logic  core_r_enable,
    output addr_t core_init_i,
    output data_t core_init_acc,
    output logic  core_control_arr,
    output logic  core_arr_wen,
    output addr_t core_arr_addr,
    output data_t core_arr_wdata,
    input  data_t core_arr_rdata,
    input  logic  core_w_enable,
    input  logic  core_result
);
    state_t     r_state;
    addr_t      r_addr, r_init_i;
    data_t      r_init_acc;
    logic       r_cmd_ready, r_in_ready, r_busy, r_ren, r_ctrl;
    logic       r_first, r_rd_done, r_infl, r_infl_last;
    logic       w_wen, w_pop, w_issue, w_out_valid, w_out_last, w_unused;
    logic [1:0] w_count;
    logic [2:0] w_occ;
    assign w_unused         = core_result;
    assign w_wen            = r_in_ready && host.in_valid;
    assign w_pop            = w_out_valid && host.out_ready;
    assign w_occ            = 3'(w_count) + 3'(r_infl) - 3'(w_pop);
    assign w_issue          = r_state == DRAIN && !r_rd_done && w_occ < 3'd2;
    assign host.cmd_ready   = r_cmd_ready;
    assign host.in_ready    = r_in_ready;
    assign host.busy        = r_busy;
    assign host.out_valid   = w_out_valid;
    assign host.out_last    = w_out_last;
    assign core_r_enable    = r_ren;
    assign core_control_arr = r_ctrl;
    assign core_init_i      = r_init_i;
    assign core_init_acc    = r_init_acc;
    assign core_arr_wen     = w_wen;
    assign core_arr_addr    = r_addr;
    assign core_arr_wdata   = host.in_data;
    bridge_skid_buffer u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_infl),
        .i_data  (core_arr_rdata),
        .i_last  (r_infl_last),
        .i_ready (host.out_ready),
        .o_valid (w_out_valid),
        .o_data  (host.out_data),
        .o_last  (w_out_last),
        .o_count (w_count)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_init_i    <= '0;
            r_init_acc  <= '0;
            r_cmd_ready <= 1'b1;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_ren       <= 1'b1;
            r_ctrl      <= 1'b0;
            r_first     <= 1'b0;
            r_rd_done   <= 1'b0;
            r_infl      <= 1'b0;
            r_infl_last <= 1'b0;
        end else begin
            r_infl      <= w_issue;
            r_infl_last <= w_issue && r_addr == LAST_ADDR;
            case (r_state)
                IDLE: if (host.cmd_valid) begin
                    r_init_i    <= host.cmd_init_i;
                    r_init_acc  <= host.cmd_init_acc;
                    r_addr      <= '0;
                    r_state     <= LOAD;
                    r_cmd_ready <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b1;
                    r_ctrl      <= 1'b1;
                end
                LOAD: if (w_wen) begin
                    if (r_addr == LAST_ADDR) begin
                        r_addr     <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_ctrl     <= 1'b0;
                        r_ren      <= 1'b0;
                        r_first    <= 1'b1;
                    end else
                        r_addr <= r_addr + ADDR_W'(1);
                end
                // A stale done flag from the previous run is still visible in the first RUN cycle.
                RUN: begin
                    r_first <= 1'b0;
                    if (!r_first && core_w_enable) begin
                        r_state   <= DRAIN;
                        r_ren     <= 1'b1;
                        r_ctrl    <= 1'b1;
                        r_rd_done <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (w_issue) begin
                        r_addr    <= r_addr == LAST_ADDR ? '0 : r_addr + ADDR_W'(1);
                        r_rd_done <= r_addr == LAST_ADDR;
                    end
                    if (w_pop && w_out_last) begin
                        r_state     <= IDLE;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_ctrl      <= 1'b0;
                    end
                end
            endcase
        end
endmodule
